// File: rtl/fc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fc_pkg                                                            |
// | Brief  : Shared FC-layer dimensions, fixed-point shift and loader states.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package fc_pkg;

    localparam int BITWIDTH   = 32;
    localparam int N_IN       = 10;
    localparam int N_OUT      = 10;
    localparam int FRAC_SHIFT = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_F = 2'd2,
        HOLD   = 2'd3
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/fc_operand_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fc_operand_loader_if                                              |
// | Brief  : Valid/ready element stream feeding the FC operand loader.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fc_operand_loader_if #(
    parameter int BITWIDTH = fc_pkg::BITWIDTH
);
    logic                       s_valid;
    logic                       s_ready;
    logic signed [BITWIDTH-1:0] s_data;
    logic                       s_last;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/fc_beat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fc_beat_counter                                                   |
// | Brief  : Clearable beat counter with a run-time terminal-count compare.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fc_beat_counter #(
    parameter int WIDTH = 7
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             inc,
    input  wire logic [WIDTH-1:0] term,
    output logic      [WIDTH-1:0] count,
    output logic                  at_term
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == term);

endmodule
`default_nettype wire

// File: rtl/fc_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fc_operand_loader                                                 |
// | Brief  : Streams a weight matrix then a featuremap into held FC operands.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fc_operand_loader #(
    parameter int BITWIDTH = fc_pkg::BITWIDTH,
    parameter int N_OUT    = fc_pkg::N_OUT,
    parameter int N_IN     = fc_pkg::N_IN
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start,
    input  wire logic                consume,
    fc_operand_loader_if.slave       s,
    output logic signed [BITWIDTH-1:0] connect_matrix [N_OUT][N_IN],
    output logic signed [BITWIDTH-1:0] featuremap3 [N_IN],
    output logic                     operands_valid,
    output logic                     err_len
);
    import fc_pkg::*;

    localparam int N_W     = N_OUT * N_IN;
    localparam int CNT_W   = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int F_IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] TERM_W = CNT_W'(N_W - 1);
    localparam logic [CNT_W-1:0] TERM_F = CNT_W'(N_IN - 1);

    loader_state_e state, state_next;

    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] beat_cnt;
    logic             at_term;
    logic             w_we;
    logic             f_we;
    logic             err_set;
    logic             err_clr;

    // Weights kept flat so the beat index addresses them without a divider.
    logic signed [BITWIDTH-1:0] w_mem [N_W];

    assign s.s_ready      = (state == LOAD_W) || (state == LOAD_F);
    assign accept         = s.s_valid && s.s_ready;
    assign operands_valid = (state == HOLD);
    assign cnt_term       = (state == LOAD_F) ? TERM_F : TERM_W;

    fc_beat_counter #(
        .WIDTH (CNT_W)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .term    (cnt_term),
        .count   (beat_cnt),
        .at_term (at_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        w_we       = 1'b0;
        f_we       = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_W;
                    cnt_clear  = 1'b1;
                    err_clr    = 1'b1;
                end
            end
            LOAD_W: begin
                if (accept) begin
                    // No weight beat can legitimately close the frame.
                    if (s.s_last) begin
                        err_set    = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        w_we = 1'b1;
                        if (at_term) begin
                            cnt_clear  = 1'b1;
                            state_next = LOAD_F;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            LOAD_F: begin
                if (accept) begin
                    if (at_term) begin
                        f_we       = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = s.s_last ? HOLD : IDLE;
                        err_set    = !s.s_last;
                    end else if (s.s_last) begin
                        err_set    = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        f_we    = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (consume) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_len <= 1'b0;
        end else if (err_clr) begin
            err_len <= 1'b0;
        end else if (err_set) begin
            err_len <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_W; k++) begin
                w_mem[k] <= '0;
            end
        end else if (w_we) begin
            w_mem[beat_cnt] <= s.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++) begin
                featuremap3[k] <= '0;
            end
        end else if (f_we) begin
            featuremap3[beat_cnt[F_IDX_W-1:0]] <= s.s_data;
        end
    end

    for (genvar r = 0; r < N_OUT; r++) begin : g_row
        for (genvar c = 0; c < N_IN; c++) begin : g_col
            assign connect_matrix[r][c] = w_mem[r*N_IN + c];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fc_operand_loader                                              |
// | Brief  : Directed loads with a queued scoreboard for completion/error.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fc_operand_loader;

    localparam int BW = 32;
    localparam int NO = 10;
    localparam int NI = 10;
    localparam int NB = NO*NI + NI;

    typedef struct {
        bit    is_err;
        int    lat;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, consume;
    logic ov, err;
    logic signed [BW-1:0] cm [NO][NI];
    logic signed [BW-1:0] fm [NI];

    logic signed [BW-1:0] exp_w [NO][NI];
    logic signed [BW-1:0] exp_f [NI];

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   prev_ov = 1'b0;
    bit   prev_err = 1'b0;

    fc_operand_loader_if #(.BITWIDTH(BW)) sif ();

    fc_operand_loader #(
        .BITWIDTH (BW),
        .N_OUT    (NO),
        .N_IN     (NI)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .consume        (consume),
        .s              (sif),
        .connect_matrix (cm),
        .featuremap3    (fm),
        .operands_valid (ov),
        .err_len        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_arrays(input string name);
        int bad = 0;
        string info = "";
        for (int j = 0; j < NO; j++)
            for (int i = 0; i < NI; i++)
                if (cm[j][i] !== exp_w[j][i]) begin
                    if (bad == 0) info = $sformatf("connect_matrix[%0d][%0d] got %0d expected %0d",
                                                   j, i, cm[j][i], exp_w[j][i]);
                    bad++;
                end
        for (int i = 0; i < NI; i++)
            if (fm[i] !== exp_f[i]) begin
                if (bad == 0) info = $sformatf("featuremap3[%0d] got %0d expected %0d", i, fm[i], exp_f[i]);
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d elements differ, first %s", name, bad, info);
        end
    endtask

    // Scoreboard: each completion or error event must match the next queued expectation.
    task automatic handle_event(input bit is_err);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got is_err=%0d expected no event", is_err);
        end else begin
            e = q.pop_front();
            chk({e.tag, "_kind"}, is_err, e.is_err);
            if (e.lat > 0) chk({e.tag, "_latency"}, cyc - start_cyc + 1, e.lat);
            chk_arrays({e.tag, "_arrays"});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ov && !prev_ov) handle_event(1'b0);
            if (err && !prev_err) handle_event(1'b1);
        end
        prev_ov  = ov;
        prev_err = err;
    end

    function automatic logic signed [BW-1:0] bval(input int pat, input int k);
        int j = k / NI;
        int i = k % NI;
        int v;
        if (k < NO*NI) begin
            case (pat)
                0:       v = j*16 + i;
                1:       v = j*16 + i + 1000;
                2:       v = j*16 + i + 2000;
                default: v = -(j*16 + i) - 1;
            endcase
        end else begin
            i = k - NO*NI;
            case (pat)
                0:       v = i - 5;
                1:       v = i + 50;
                2:       v = i + 100;
                default: v = -100 - i;
            endcase
        end
        return BW'(v);
    endfunction

    task automatic model_write(input int pat, input int k);
        if (k < NO*NI) exp_w[k/NI][k%NI] = bval(pat, k);
        else           exp_f[k-NO*NI]    = bval(pat, k);
    endtask

    // One beat; leaves s_valid low with junk data/last so idle cycles are exercised.
    task automatic beat(input int pat, input int k, input bit last, input bit toggle, input bit wr);
        int tries = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = bval(pat, k);
        sif.s_last  = last;
        while (!sif.s_ready && tries < 8) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!sif.s_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_%0d_ready: got s_ready=0 expected 1 within 8 cycles", k);
        end
        @(posedge clk); #1;
        if (wr) model_write(pat, k);
        sif.s_valid = 1'b0;
        sif.s_data  = 32'sh5A5A_A5A5;
        sif.s_last  = 1'b1;
        if (toggle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int pat, input int first, input int count, input bit toggle);
        for (int k = first; k < first + count; k++) beat(pat, k, k == NB-1, toggle, 1'b1);
    endtask

    task automatic do_start();
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_consume(input string name);
        consume = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        consume = 1'b0;
        start   = 1'b0;
        chk({name, "_valid_dropped"}, ov, 0);
        chk({name, "_ready_low"}, sif.s_ready, 0);
        @(posedge clk); #1;
        chk({name, "_start_ignored"}, sif.s_ready, 0);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        errors++;
        $display("FAIL timeout: got no end of test expected finish within 20000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        for (int j = 0; j < NO; j++) for (int i = 0; i < NI; i++) exp_w[j][i] = '0;
        for (int i = 0; i < NI; i++) exp_f[i] = '0;
        rst = 1'b1; start = 1'b1; consume = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = '0; sif.s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", sif.s_ready, 0);
        chk("reset_valid", ov, 0);
        chk("reset_err", err, 0);
        chk_arrays("reset_arrays");
        rst = 1'b0; start = 1'b0; sif.s_valid = 1'b0;
        @(posedge clk); #1;

        // Full load with continuous valid.
        q.push_back('{1'b0, 112, "load_a"});
        do_start();
        send(0, 0, NB, 1'b0);
        chk("load_a_valid", ov, 1);
        chk("load_a_cm73", cm[7][3], 115);
        chk("load_a_fm0", fm[0], -5);
        chk("load_a_fm9", fm[9], 4);
        chk("hold_ready", sif.s_ready, 0);
        sif.s_valid = 1'b1; sif.s_data = 32'sd999; sif.s_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
        chk("hold_still_valid", ov, 1);
        chk_arrays("hold_frozen");
        do_consume("hold_a");

        // Same load with valid toggling 1,0.
        q.push_back('{1'b0, 221, "load_a_toggle"});
        do_start();
        send(0, 0, NB, 1'b1);
        chk("toggle_valid", ov, 1);
        do_consume("hold_toggle");

        // s_last on beat 50; start/consume strobed mid-load must be ignored.
        q.push_back('{1'b1, 0, "last_early"});
        do_start();
        send(1, 0, 10, 1'b0);
        start = 1'b1; consume = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; consume = 1'b0;
        send(1, 10, 40, 1'b0);
        beat(1, 50, 1'b1, 1'b0, 1'b0);
        chk("early_err", err, 1);
        chk("early_valid", ov, 0);
        chk("early_idle_ready", sif.s_ready, 0);
        chk("early_cm50_kept", cm[5][0], 80);
        chk("early_cm49_new", cm[4][9], 1073);

        // Final beat without s_last.
        q.push_back('{1'b1, 0, "final_no_last"});
        do_start();
        chk("start_clears_err", err, 0);
        send(2, 0, NB-1, 1'b0);
        beat(2, NB-1, 1'b0, 1'b0, 1'b1);
        chk("nolast_err", err, 1);
        chk("nolast_valid", ov, 0);
        chk("nolast_fm9_written", fm[9], 109);
        repeat (3) @(posedge clk);
        #1;
        chk("nolast_valid_stays_low", ov, 0);

        // Reset at beat 60 overrides start/consume/valid.
        do_start();
        send(3, 0, 60, 1'b0);
        sif.s_valid = 1'b1; sif.s_data = bval(3, 60); sif.s_last = 1'b0;
        rst = 1'b1; start = 1'b1; consume = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; consume = 1'b0; sif.s_valid = 1'b0;
        for (int j = 0; j < NO; j++) for (int i = 0; i < NI; i++) exp_w[j][i] = '0;
        for (int i = 0; i < NI; i++) exp_f[i] = '0;
        chk("rst_ready", sif.s_ready, 0);
        chk("rst_valid", ov, 0);
        chk("rst_err", err, 0);
        chk_arrays("rst_arrays");

        q.push_back('{1'b0, 112, "load_after_rst"});
        do_start();
        send(0, 0, NB, 1'b0);
        chk("after_rst_cm73", cm[7][3], 115);
        do_consume("hold_after_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
